// File: rtl/amp_spi_responder.sv
// SPI responder for the preamp link: receives {gain_b,gain_a} words and
// shifts the previously held word back out on amp_dout.
// Ports: CLK50MHZ, RST (async low), spi_sck/spi_mosi/amp_cs/amp_shdn in;
//        amp_dout, gain_a, gain_b, gain_valid, frame_err out.
module amp_spi_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       amp_cs,
  input  logic       amp_shdn,
  output logic       amp_dout,
  output logic [3:0] gain_a,
  output logic [3:0] gain_b,
  output logic       gain_valid,
  output logic       frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] BITS = 4'(DATA_W);

  logic [SYNC_STAGES-1:0] sck_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic [SYNC_STAGES-1:0] cs_s;
  logic [SYNC_STAGES-1:0] shdn_s;

  logic sck_q;
  logic cs_q;

  logic sck_m;
  logic mosi_m;
  logic cs_m;
  logic shdn_m;

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [1:0]        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [3:0]        bit_cnt;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      sck_s  <= '0;
      mosi_s <= '0;
      cs_s   <= '0;
      shdn_s <= '0;
      sck_q  <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], spi_sck};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], amp_cs};
      shdn_s <= {shdn_s[SYNC_STAGES-2:0], amp_shdn};
      sck_q  <= sck_s[SYNC_STAGES-1];
      cs_q   <= cs_s[SYNC_STAGES-1];
    end
  end

  assign sck_m  = sck_s[SYNC_STAGES-1];
  assign mosi_m = mosi_s[SYNC_STAGES-1];
  assign cs_m   = cs_s[SYNC_STAGES-1];
  assign shdn_m = shdn_s[SYNC_STAGES-1];

  assign sck_rise = sck_m & ~sck_q;
  assign sck_fall = ~sck_m & sck_q;
  assign cs_rise  = cs_m & ~cs_q;
  assign cs_fall  = ~cs_m & cs_q;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      amp_dout   <= 1'b0;
      gain_a     <= '0;
      gain_b     <= '0;
      gain_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      gain_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (shdn_m) begin
        // shutdown clears the held gains and drops any open frame
        state    <= IDLE;
        gain_a   <= '0;
        gain_b   <= '0;
        amp_dout <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              tx_sr    <= {gain_b, gain_a};
              amp_dout <= gain_b[3];
              bit_cnt  <= '0;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            // CS edge takes priority over a same-cycle SCK edge
            if (cs_rise) begin
              state <= DONE;
            end else if (sck_rise) begin
              rx_sr <= {rx_sr[DATA_W-2:0], mosi_m};
              if (bit_cnt != 4'hF)
                bit_cnt <= bit_cnt + 4'd1;
            end else if (sck_fall) begin
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
              amp_dout <= tx_sr[DATA_W-2];
            end
          end
          DONE: begin
            if (bit_cnt == BITS) begin
              gain_b     <= rx_sr[7:4];
              gain_a     <= rx_sr[3:0];
              gain_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            amp_dout <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/amp_spi_responder.md
Name: amp_spi_responder

Overview:
- SPI responder (slave) for the programmable preamp serial link: the device-side end of the link driven by the amp controller over SPI_SCK/SPI_MOSI/AMP_CS/AMP_SHDN.
- Receives 8-bit gain words, holds the A/B gain registers and shifts the previously held word back out on amp_dout, LTC6912-style.
- Used as a synthesizable loopback target on the board and as the bench responder for the amp controller.

Parameters:
- DATA_W, 8, frame length in bits; the word is {gain_b[3:0], gain_a[3:0]}, MSB first.
- SYNC_STAGES, 2, flip-flop synchronizer depth on spi_sck, spi_mosi, amp_cs and amp_shdn.

Ports:
- CLK50MHZ  input  1  system clock; all logic is on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- spi_sck  input  1  SPI clock from the initiator; idle low.
- spi_mosi  input  1  serial data in, sampled on SCK rising.
- amp_cs  input  1  chip select, active low, frames a transfer.
- amp_shdn  input  1  shutdown, active high.
- amp_dout  output  1  serial data out; changes on SCK falling.
- gain_a  output  4  current channel A gain code.
- gain_b  output  4  current channel B gain code.
- gain_valid  output  1  one-cycle pulse when a new word is committed.
- frame_err  output  1  one-cycle pulse when a frame ends with bit count != DATA_W.

Behaviour:
- Reset (RST=0): gain_a=0, gain_b=0, amp_dout=0, gain_valid=0, frame_err=0. The shift registers, bit counter and edge detectors are cleared, and the FSM goes to IDLE. Reset takes effect immediately even mid-frame; no commit occurs.
- Inputs pass through SYNC_STAGES flip-flops, then one edge-detect register. A pin edge is therefore acted on at cycle SYNC_STAGES+1 after it is seen. Requirement: the SCK half-period must be at least 6 CLK50MHZ cycles (SCK ≤ ~4 MHz).
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On a detected CS falling edge with shdn=0: load tx_sr <= {gain_b, gain_a}, set amp_dout <= tx_sr MSB, clear bit_cnt, go to SHIFT.
  - SCK edges are ignored.
- SHIFT:
  - On SCK rising: rx_sr <= {rx_sr[DATA_W-2:0], mosi_sync}. bit_cnt increments and saturates at 15.
  - On SCK falling: tx_sr shifts left with 0 fill; amp_dout <= next MSB. After DATA_W bits amp_dout drives 0.
  - On CS rising: go to DONE.
- DONE (one cycle):
  - If bit_cnt == DATA_W: gain_b <= rx_sr[7:4], gain_a <= rx_sr[3:0], pulse gain_valid.
  - Otherwise the gains are unchanged and frame_err pulses.
  - Then go to IDLE; amp_dout <= 0.
- Simultaneous events: if a CS rising edge and an SCK edge are detected in the same cycle, CS wins and the SCK edge is ignored. A CS falling edge in DONE is not possible, because CS must stay high at least 2 SCK half-periods.
- Shutdown:
  - Synchronized shdn=1 forces gain_a=gain_b=0 and amp_dout=0.
  - Any frame in progress is aborted to IDLE with no commit and no frame_err.
  - A CS falling edge while shdn=1 is ignored.
- gain_valid and frame_err are never asserted in the same cycle.

Test Plan:
- Reset then frame 0x5A (8 SCK cycles, CS low) -> gain_b=4'h5, gain_a=4'hA, one gain_valid pulse, amp_dout shifts out 0x00.
- Second frame 0x3C after 0x5A -> amp_dout bits on successive SCK rising edges read 0,1,0,1,1,0,1,0 (0x5A); gains become 3/C.
- 7-bit frame, then a 9-bit frame -> frame_err pulses once per frame, gains remain at previous 3/C, no gain_valid.
- amp_shdn=1 mid-frame after 4 bits -> gains 0 and amp_dout 0 within SYNC_STAGES+1 cycles, no commit; after shdn=0 a frame 0x11 commits 1/1.
- RST low during bit 5 of frame 0xFF -> all outputs 0 immediately; the remaining SCK edges with CS low produce no commit and no frame_err until a new CS falling edge.
- SCK toggling with CS high, plus CS rising coincident with the last SCK rising edge -> no state change; the coincident edge is dropped, giving a 7-bit count and frame_err.
